// File: rtl/alu_frame_deserializer.sv
// Serial frame receiver: NUM_OPS operands of DATA_W bits plus a command byte, CRC4-checked, valid/ready output.
// Optional op-code filtering is compiled in with `define ALU_DESER_OP_CHECK_EN.
module alu_frame_deserializer #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_OPS  = 2,
  parameter int unsigned IDLE_GAP = 11
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sin,
  output logic [NUM_OPS*DATA_W-1:0]   operands,
  output logic [7:0]                  ctl,
  output logic                        out_err,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        overrun
);

  localparam int unsigned TOT   = NUM_OPS * DATA_W;
  localparam int unsigned P     = TOT / 8;
  localparam int unsigned CNT_W = $clog2(P + 1);
  localparam int unsigned GAP_W = $clog2(IDLE_GAP + 1);
  localparam logic [CNT_W-1:0] P_C      = CNT_W'(P);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_GAP - 1);
  localparam logic [7:0] ERR_DATA = 8'hC9;
  localparam logic [7:0] ERR_CRC  = 8'hA5;
  localparam logic [7:0] CTL_IDLE = 8'hFF;
`ifdef ALU_DESER_OP_CHECK_EN
  localparam logic [7:0] ERR_OP   = 8'h93;
`endif

  typedef enum logic [1:0] {S_IDLE, S_PKT, S_CHECK, S_ERROR} state_t;
  state_t state, state_nx;

  logic [3:0]       bit_idx;
  logic [CNT_W-1:0] pkt_cnt;
  logic             is_cmd;
  logic             err_pend;
  logic [GAP_W-1:0] gap_cnt;
  logic [TOT-1:0]   arr_sr;
  logic [7:0]       cmd_sr;
  logic             det_err;
  logic             data_done;

  logic [TOT-1:0]   rx_ops;
  logic [TOT+2:0]   msg;
  logic [3:0]       crc_calc;
  logic             crc_fb;
  logic [7:0]       res_ctl;
  logic             res_err;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    det_err   = 1'b0;
    data_done = 1'b0;
    unique case (state)
      S_IDLE: if (!sin) state_nx = S_PKT;
      S_PKT: begin
        // type bit must be CMD exactly when all DATA packets have arrived
        if (bit_idx == 4'd1) begin
          if (sin != (pkt_cnt == P_C)) det_err = 1'b1;
        end else if (bit_idx == 4'd2) begin
          if (is_cmd && sin) det_err = 1'b1;
        end else if (bit_idx == 4'd10) begin
          if (!sin)        det_err = 1'b1;
          else if (is_cmd) state_nx = S_CHECK;
          else begin
            state_nx  = S_IDLE;
            data_done = 1'b1;
          end
        end
        if (det_err) state_nx = S_CHECK;
      end
      S_CHECK: state_nx = err_pend ? S_ERROR : S_IDLE;
      S_ERROR: if (sin && gap_cnt == GAP_LAST) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_idx  <= 4'd0;
      pkt_cnt  <= '0;
      is_cmd   <= 1'b0;
      err_pend <= 1'b0;
      gap_cnt  <= '0;
      arr_sr   <= '0;
      cmd_sr   <= '0;
    end else begin
      unique case (state)
        S_IDLE: bit_idx <= 4'd1;
        S_PKT: begin
          bit_idx  <= bit_idx + 4'd1;
          err_pend <= det_err;
          if (bit_idx == 4'd1) is_cmd <= sin;
          if (bit_idx >= 4'd2 && bit_idx <= 4'd9) begin
            if (is_cmd) cmd_sr <= {cmd_sr[6:0], sin};
            else        arr_sr <= {arr_sr[TOT-2:0], sin};
          end
          if (data_done) pkt_cnt <= pkt_cnt + CNT_W'(1);
        end
        S_CHECK: begin
          pkt_cnt <= '0;
          gap_cnt <= '0;
        end
        S_ERROR: gap_cnt <= sin ? gap_cnt + GAP_W'(1) : '0;
        default: ;
      endcase
    end
  end

  // arrival order puts operand 0 in the top word; output packing wants it at the bottom
  always_comb begin
    rx_ops = '0;
    for (int unsigned k = 0; k < NUM_OPS; k++)
      rx_ops[k*DATA_W +: DATA_W] = arr_sr[(NUM_OPS-1-k)*DATA_W +: DATA_W];
  end

  always_comb begin
    msg      = {rx_ops, cmd_sr[6:4]};
    crc_calc = '0;
    crc_fb   = 1'b0;
    for (int unsigned i = 0; i < TOT + 3; i++) begin
      crc_fb   = crc_calc[3] ^ msg[TOT+2-i];
      crc_calc = {crc_calc[2:0], 1'b0} ^ {2'b00, crc_fb, crc_fb};
    end
  end

  always_comb begin
    res_err = 1'b1;
    res_ctl = ERR_DATA;
    if (err_pend) begin
      res_ctl = ERR_DATA;
    end else if (crc_calc != cmd_sr[3:0]) begin
      res_ctl = ERR_CRC;
`ifdef ALU_DESER_OP_CHECK_EN
    end else if (!(cmd_sr[6:4] inside {3'b000, 3'b001, 3'b100, 3'b101})) begin
      res_ctl = ERR_OP;
`endif
    end else begin
      res_err = 1'b0;
      res_ctl = cmd_sr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      operands  <= '0;
      ctl       <= CTL_IDLE;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (state == S_CHECK) begin
        if (out_valid && !out_ready) begin
          overrun <= 1'b1;
        end else begin
          out_valid <= 1'b1;
          ctl       <= res_ctl;
          out_err   <= res_err;
          if (!res_err) operands <= rx_ops;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        ctl       <= CTL_IDLE;
        out_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_frame_deserializer.sv
// Randomized self-checking bench for alu_frame_deserializer against a frame-level reference model.
module tb_alu_frame_deserializer;

`ifdef ALU_DESER_OP_CHECK_EN
  localparam bit OP_CHECK = 1'b1;
`else
  localparam bit OP_CHECK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic [63:0] operands;
  logic [7:0]  ctl;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;

  alu_frame_deserializer #(.DATA_W(32), .NUM_OPS(2), .IDLE_GAP(11)) dut (
    .clk(clk), .rst(rst), .sin(sin), .operands(operands), .ctl(ctl),
    .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ovr_cnt = 0, ovr_run = 0, ovr_max = 0;

  always @(negedge clk) begin
    if (overrun === 1'b1) begin
      ovr_cnt++;
      ovr_run++;
      if (ovr_run > ovr_max) ovr_max = ovr_run;
    end else begin
      ovr_run = 0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CRC by polynomial long division of message * x^4 by x^4+x+1
  function automatic logic [3:0] crc_ref(input logic [63:0] ops, input logic [2:0] op);
    logic [70:0] m;
    m = {ops, op, 4'b0000};
    for (int i = 70; i >= 4; i--)
      if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
    return m[3:0];
  endfunction

  bit          frame_bits[$];
  logic [63:0] exp_ops, pred_ops;
  logic [7:0]  exp_ctl, pred_ctl;
  logic        exp_err, pred_err;

  function automatic void push_pkt(input bit typ, input logic [7:0] b);
    frame_bits.push_back(1'b0);
    frame_bits.push_back(typ);
    for (int i = 7; i >= 0; i--) frame_bits.push_back(b[i]);
    frame_bits.push_back(1'b1);
  endfunction

  function automatic void load_frame(input logic [63:0] ops, input logic [2:0] op,
                                     input logic [3:0] crc_x, input int n_data);
    logic [7:0] cmd;
    cmd = {1'b0, op, crc_ref(ops, op) ^ crc_x};
    frame_bits.delete();
    for (int b = 0; b < n_data; b++)
      push_pkt(1'b0, ops[(b/4)*32 + (3 - b%4)*8 +: 8]);
    push_pkt(1'b1, cmd);
    pred_ops = exp_ops;
    pred_err = 1'b1;
    if (n_data != 8)                                                   pred_ctl = 8'hC9;
    else if (crc_x != 4'd0)                                            pred_ctl = 8'hA5;
    else if (OP_CHECK && !(op inside {3'b000, 3'b001, 3'b100, 3'b101})) pred_ctl = 8'h93;
    else begin
      pred_err = 1'b0;
      pred_ctl = cmd;
      pred_ops = ops;
    end
  endfunction

  task automatic commit();
    exp_ops = pred_ops;
    exp_ctl = pred_ctl;
    exp_err = pred_err;
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) begin
      sin = frame_bits[i];
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    sin = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_held(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_ctl"},   64'(ctl),       64'(exp_ctl));
    check({tag, "_err"},   64'(out_err),   64'(exp_err));
    check({tag, "_ops"},   operands,       exp_ops);
  endtask

  task automatic wait_valid(input string tag);
    int waited = 0;
    while (out_valid !== 1'b1 && waited < 60) begin
      @(posedge clk); #1;
      waited++;
    end
    check({tag, "_wait"}, 64'(out_valid), 64'd1);
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_acc_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_acc_ctl"},   64'(ctl),       64'hFF);
    check({tag, "_acc_ops"},   operands,       exp_ops);
  endtask

  // full frame from idle output: result must appear exactly one cycle after the CHECK cycle
  task automatic do_frame(input string tag, input logic [63:0] ops, input logic [2:0] op,
                          input logic [3:0] crc_x);
    load_frame(ops, op, crc_x, 8);
    send_bits(frame_bits.size());
    check({tag, "_lat1"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    commit();
    check_held(tag);
  endtask

  logic [63:0] ops_a = 64'h00000002_00000001;
  logic [63:0] ops_x, ops_y;
  logic [3:0]  cx;
  int          ovr0;

  initial begin
    rst = 1'b0; sin = 1'b1; out_ready = 1'b0;
    exp_ops = '0; exp_ctl = 8'hFF; exp_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ops",   operands,          64'd0);
    check("rst_ctl",   64'(ctl),          64'hFF);
    check("rst_err",   64'(out_err),      64'd0);
    check("rst_valid", 64'(out_valid),    64'd0);
    check("rst_ovr",   64'(overrun),      64'd0);
    rst = 1'b1;
    idle(2);

    do_frame("good", ops_a, 3'b100, 4'd0);
    check("good_ctl40", 64'(ctl), 64'h40);
    accept("good");

    do_frame("crc", ops_a, 3'b100, 4'd1);
    idle(12);
    accept("crc");

    load_frame(ops_a, 3'b100, 4'd0, 7);
    send_bits(frame_bits.size());
    wait_valid("short");
    commit();
    check_held("short");
    idle(11);
    accept("short");
    do_frame("recover", ops_a, 3'b100, 4'd0);
    accept("recover");

    ops_x = {$urandom, $urandom};
    ops_y = {$urandom, $urandom};
    ovr0 = ovr_cnt;
    do_frame("ovr_first", ops_x, 3'b101, 4'd0);
    load_frame(ops_y, 3'b000, 4'd0, 8);
    send_bits(frame_bits.size());
    idle(3);
    check("ovr_count", 64'(ovr_cnt - ovr0), 64'd1);
    check("ovr_width", 64'(ovr_max), 64'd1);
    check_held("ovr_held");
    accept("ovr");

    do_frame("same_first", ops_x, 3'b001, 4'd0);
    ovr0 = ovr_cnt;
    load_frame(ops_y, 3'b100, 4'd0, 8);
    send_bits(frame_bits.size());
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    commit();
    check_held("same_new");
    idle(2);
    check("same_no_ovr", 64'(ovr_cnt - ovr0), 64'd0);
    accept("same");

    load_frame(ops_a, 3'b100, 4'd0, 8);
    send_bits(5*11 + 4);
    rst = 1'b0; sin = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("mrst_ops",   operands,       64'd0);
    check("mrst_ctl",   64'(ctl),       64'hFF);
    check("mrst_valid", 64'(out_valid), 64'd0);
    rst = 1'b1;
    exp_ops = '0;
    idle(2);
    do_frame("mrst", ops_a, 3'b100, 4'd0);
    check("mrst_ctl40", 64'(ctl), 64'h40);
    accept("mrst");

    do_frame("op010", {$urandom, $urandom}, 3'b010, 4'd0);
    idle(12);
    accept("op010");

    for (int it = 0; it < 40; it++) begin
      ops_x = {$urandom, $urandom};
      cx = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      if ($urandom_range(0, 9) == 0) begin
        load_frame(ops_x, 3'($urandom_range(0, 7)), 4'd0, 7);
        send_bits(frame_bits.size());
        wait_valid("rnd_short");
        commit();
        check_held("rnd_short");
        idle(12);
      end else begin
        do_frame("rnd", ops_x, 3'($urandom_range(0, 7)), cx);
        if (exp_err) idle(12);
      end
      idle($urandom_range(0, 4));
      check("rnd_stable_ctl", 64'(ctl), 64'(exp_ctl));
      accept("rnd");
      idle($urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
